cdb_driver: RTL

Producer side of the common data bus. Collects completed results from the ALU, multiplier, branch and memory units through per-channel valid/ready FIFOs, drives one registered broadcast per channel per cycle onto `cdbus`, and raises `flush` when a mispredicted branch is broadcast. It also forwards the ROB commit strobe (`regf_we`, `commit_rob_idx`). Reservation stations, the ROB and the register file consume its output.

---
 rtl/cdb_driver.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/cdb_driver.sv
// Common data bus producer: four per-channel result FIFOs feeding registered
// broadcast slots, plus mispredict flush and ROB commit strobe forwarding.

package cdb_pkg;
  localparam int ROB_W = 5;

  typedef struct packed {
    logic             alu_valid;
    logic [31:0]      alu_data;
    logic [4:0]       alu_rd_addr;
    logic [ROB_W-1:0] alu_rob_idx;
    logic             mul_valid;
    logic [31:0]      mul_data;
    logic [4:0]       mul_rd_addr;
    logic [ROB_W-1:0] mul_rob_idx;
    logic             br_valid;
    logic [31:0]      br_data;
    logic [4:0]       br_rd_addr;
    logic [ROB_W-1:0] br_rob_idx;
    logic             mem_valid;
    logic [31:0]      mem_data;
    logic [4:0]       mem_rd_addr;
    logic [ROB_W-1:0] mem_rob_idx;
    logic [3:0]       mem_wmask;
    logic             flush;
    logic             regf_we;
    logic [ROB_W-1:0] commit_rob_idx;
  } cdb;
endpackage

// One channel: circular FIFO with an empty-FIFO bypass into the broadcast slot.
module cdb_chan #(
  parameter int DEPTH = 4,
  parameter int W     = 42
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push_valid,
  input  logic [W-1:0] push_payload,
  output logic         push_ready,
  output logic         bcast_valid,
  output logic [W-1:0] bcast_payload
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic             valid_q, valid_d;
  logic [W-1:0]     data_q, data_d;
  logic             push, pop, wr;

  assign push_ready = !rst && (count_q < CNT_W'(DEPTH));

  always_comb begin
    push    = push_valid && push_ready;
    pop     = (count_q != '0);
    wr      = push && pop;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    valid_d = 1'b0;
    data_d  = data_q;
    if (flush) begin
      // pushes taken during the flush cycle are discarded along with the queue
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        valid_d = 1'b1;
        data_d  = mem_q[head_q];
        head_d  = head_q + PTR_W'(1);
      end else if (push) begin
        valid_d = 1'b1;
        data_d  = push_payload;
      end
      if (wr) begin
        mem_d[tail_q] = push_payload;
        tail_d        = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(wr) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bcast_valid   = valid_q;
  assign bcast_payload = data_q;
endmodule

module cdb_driver
  import cdb_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int ROB_IDX_WIDTH = cdb_pkg::ROB_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_req_valid,
  output logic                     alu_req_ready,
  input  logic [31:0]              alu_req_data,
  input  logic [4:0]               alu_req_rd_addr,
  input  logic [ROB_IDX_WIDTH-1:0] alu_req_rob_idx,
  input  logic                     mul_req_valid,
  output logic                     mul_req_ready,
  input  logic [31:0]              mul_req_data,
  input  logic [4:0]               mul_req_rd_addr,
  input  logic [ROB_IDX_WIDTH-1:0] mul_req_rob_idx,
  input  logic                     br_req_valid,
  output logic                     br_req_ready,
  input  logic [31:0]              br_req_data,
  input  logic [4:0]               br_req_rd_addr,
  input  logic [ROB_IDX_WIDTH-1:0] br_req_rob_idx,
  input  logic                     br_req_mispredict,
  input  logic                     mem_req_valid,
  output logic                     mem_req_ready,
  input  logic [31:0]              mem_req_data,
  input  logic [4:0]               mem_req_rd_addr,
  input  logic [ROB_IDX_WIDTH-1:0] mem_req_rob_idx,
  input  logic [3:0]               mem_req_wmask,
  input  logic                     commit_valid,
  input  logic [ROB_IDX_WIDTH-1:0] commit_rob_idx_in,
  output cdb                       cdbus
);
  localparam int BASE_W = 32 + 5 + ROB_IDX_WIDTH;

  logic              alu_v, mul_v, br_v, mem_v;
  logic [BASE_W-1:0] alu_bc, mul_bc;
  logic [BASE_W:0]   br_bc;
  logic [BASE_W+3:0] mem_bc;
  logic              flush;

  logic                     regf_we_q, regf_we_d;
  logic [ROB_IDX_WIDTH-1:0] commit_idx_q, commit_idx_d;

  // Both operands are flops, so flush is a registered-domain signal that
  // coincides with the mispredicting branch's broadcast.
  assign flush = br_v && br_bc[0];

  cdb_chan #(.DEPTH(FIFO_DEPTH), .W(BASE_W)) u_alu (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(alu_req_valid),
    .push_payload({alu_req_data, alu_req_rd_addr, alu_req_rob_idx}),
    .push_ready(alu_req_ready),
    .bcast_valid(alu_v), .bcast_payload(alu_bc)
  );

  cdb_chan #(.DEPTH(FIFO_DEPTH), .W(BASE_W)) u_mul (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(mul_req_valid),
    .push_payload({mul_req_data, mul_req_rd_addr, mul_req_rob_idx}),
    .push_ready(mul_req_ready),
    .bcast_valid(mul_v), .bcast_payload(mul_bc)
  );

  cdb_chan #(.DEPTH(FIFO_DEPTH), .W(BASE_W + 1)) u_br (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(br_req_valid),
    .push_payload({br_req_data, br_req_rd_addr, br_req_rob_idx, br_req_mispredict}),
    .push_ready(br_req_ready),
    .bcast_valid(br_v), .bcast_payload(br_bc)
  );

  cdb_chan #(.DEPTH(FIFO_DEPTH), .W(BASE_W + 4)) u_mem (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(mem_req_valid),
    .push_payload({mem_req_data, mem_req_rd_addr, mem_req_rob_idx, mem_req_wmask}),
    .push_ready(mem_req_ready),
    .bcast_valid(mem_v), .bcast_payload(mem_bc)
  );

  always_comb begin
    regf_we_d    = commit_valid;
    commit_idx_d = commit_rob_idx_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regf_we_q    <= 1'b0;
      commit_idx_q <= '0;
    end else begin
      regf_we_q    <= regf_we_d;
      commit_idx_q <= commit_idx_d;
    end
  end

  always_comb begin
    cdbus                = '0;
    cdbus.alu_valid      = alu_v;
    cdbus.alu_data       = alu_bc[BASE_W-1 -: 32];
    cdbus.alu_rd_addr    = alu_bc[ROB_IDX_WIDTH +: 5];
    cdbus.alu_rob_idx    = alu_bc[ROB_IDX_WIDTH-1:0];
    cdbus.mul_valid      = mul_v;
    cdbus.mul_data       = mul_bc[BASE_W-1 -: 32];
    cdbus.mul_rd_addr    = mul_bc[ROB_IDX_WIDTH +: 5];
    cdbus.mul_rob_idx    = mul_bc[ROB_IDX_WIDTH-1:0];
    cdbus.br_valid       = br_v;
    cdbus.br_data        = br_bc[BASE_W -: 32];
    cdbus.br_rd_addr     = br_bc[ROB_IDX_WIDTH+1 +: 5];
    cdbus.br_rob_idx     = br_bc[ROB_IDX_WIDTH:1];
    cdbus.mem_valid      = mem_v;
    cdbus.mem_data       = mem_bc[BASE_W+3 -: 32];
    cdbus.mem_rd_addr    = mem_bc[ROB_IDX_WIDTH+4 +: 5];
    cdbus.mem_rob_idx    = mem_bc[ROB_IDX_WIDTH+3:4];
    cdbus.mem_wmask      = mem_bc[3:0];
    cdbus.flush          = flush;
    cdbus.regf_we        = regf_we_q;
    cdbus.commit_rob_idx = commit_idx_q;
  end
endmodule
